// File: rtl/bus_pkg.sv
// Shared encodings for the C64 bus arbiter: FSM states, DMA owner and default BA lead.
package bus_pkg;

  localparam int BA_LEAD_DEFAULT = 3;

  localparam logic [1:0] ST_CPU     = 2'd0;
  localparam logic [1:0] ST_STALL   = 2'd1;
  localparam logic [1:0] ST_OWN_VIC = 2'd2;
  localparam logic [1:0] ST_OWN_EXT = 2'd3;

  typedef enum logic {
    OWNER_VIC = 1'b0,
    OWNER_EXT = 1'b1
  } owner_t;

  // The CPU drives the bus in CPU and STALL; STALL only halts reads via RDY.
  function automatic logic cpu_has_bus(input logic [1:0] st);
    return (st == ST_CPU) || (st == ST_STALL);
  endfunction

endpackage

// File: rtl/bus_lead_counter.sv
// Saturating BA lead counter with synchronous clear and an at-limit flag.
module bus_lead_counter #(
  parameter int LIMIT = 2,
  parameter int W     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  logic [W-1:0] cnt;

  assign at_limit = (cnt == W'(LIMIT));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= {W{1'b0}};
    end else if (en && !at_limit) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// C64 bus arbiter: CPU vs VIC-II DMA vs optional expansion DMA with BA lead time.
// Expansion DMA is built only when BUS_ARBITER_EXT_DMA_EN is defined.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int BA_LEAD = BA_LEAD_DEFAULT,
  parameter int CNT_W   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic vic_req,
  input  logic ext_req,
  input  logic cpu_we,
  output logic rdy,
  output logic aec,
  output logic ba,
  output logic vic_gnt,
  output logic ext_gnt
);

  logic [1:0] state;
  logic [1:0] state_next;
  owner_t     owner;
  owner_t     eff_owner;
  logic       own_req;
  logic       at_limit;
  logic       ext_req_en;

  bus_lead_counter #(
    .LIMIT (BA_LEAD - 1),
    .W     (CNT_W)
  ) u_lead (
    .clk      (clk),
    .reset    (reset),
    .clr      (state != ST_STALL),
    .en       (state == ST_STALL),
    .at_limit (at_limit)
  );

`ifdef BUS_ARBITER_EXT_DMA_EN
  assign ext_req_en = ext_req;
  assign ext_gnt    = (state == ST_OWN_EXT);

  // Owner is chosen on STALL entry; a VIC request steals a pending EXT stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= OWNER_VIC;
    end else if (state == ST_CPU && (vic_req || ext_req_en)) begin
      owner <= vic_req ? OWNER_VIC : OWNER_EXT;
    end else if (state == ST_STALL && vic_req) begin
      owner <= OWNER_VIC;
    end else begin
      owner <= owner;
    end
  end
`else
  logic ext_req_unused;
  assign ext_req_unused = ext_req;
  assign ext_req_en     = 1'b0;
  assign ext_gnt        = 1'b0;
  assign owner          = OWNER_VIC;
`endif

  // Effective owner this cycle, so the switch to VIC does not cost a cycle.
  always_comb begin
    eff_owner = owner;
    if (owner == OWNER_EXT && vic_req) begin
      eff_owner = OWNER_VIC;
    end else begin
      eff_owner = owner;
    end
    own_req = (eff_owner == OWNER_VIC) ? vic_req : ext_req_en;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CPU: begin
        if (vic_req || ext_req_en) state_next = ST_STALL;
        else                       state_next = ST_CPU;
      end
      ST_STALL: begin
        if (!own_req)                 state_next = ST_CPU;
        else if (at_limit && !cpu_we) state_next = (eff_owner == OWNER_VIC) ? ST_OWN_VIC : ST_OWN_EXT;
        else                          state_next = ST_STALL;
      end
      ST_OWN_VIC: begin
        if (vic_req) state_next = ST_OWN_VIC;
        else         state_next = ST_CPU;
      end
      ST_OWN_EXT: begin
        if (vic_req)         state_next = ST_OWN_VIC;
        else if (ext_req_en) state_next = ST_OWN_EXT;
        else                 state_next = ST_CPU;
      end
      default: state_next = ST_CPU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CPU;
    end else begin
      state <= state_next;
    end
  end

  // rdy is combinational so pending CPU writes complete during the BA lead.
  assign rdy     = (state == ST_CPU) || (state == ST_STALL && cpu_we);
  assign aec     = cpu_has_bus(state);
  assign vic_gnt = (state == ST_OWN_VIC);
  assign ba      = !((state == ST_STALL && owner == OWNER_VIC) || state == ST_OWN_VIC);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter; outputs are packed {rdy,aec,ba,vic_gnt,ext_gnt}.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset, vic_req, ext_req, cpu_we;
  logic rdy, aec, ba, vic_gnt, ext_gnt;
  logic [4:0] outs;
  logic [4:0] sb[$];
  logic [4:0] exp_o;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign outs = {rdy, aec, ba, vic_gnt, ext_gnt};

  bus_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .vic_req (vic_req),
    .ext_req (ext_req),
    .cpu_we  (cpu_we),
    .rdy     (rdy),
    .aec     (aec),
    .ba      (ba),
    .vic_gnt (vic_gnt),
    .ext_gnt (ext_gnt)
  );

  // stim = {reset, vic_req, ext_req, cpu_we}; each row is one bus cycle
  task automatic test_reset();
    logic [3:0] stim [0:8];
    logic [4:0] expv [0:8];
    reset = 1'b1; vic_req = 1'b0; ext_req = 1'b0; cpu_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    stim = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1100, 4'b0100, 4'b0000};
    expv = '{5'b11100, 5'b11100, 5'b01000, 5'b01000, 5'b01000, 5'b00010, 5'b00010, 5'b11100, 5'b01000};
    for (int i = 0; i < 9; i++) begin
      {reset, vic_req, ext_req, cpu_we} = stim[i];
      sb.push_back(expv[i]);
      @(negedge clk);
      exp_o = sb.pop_front();
      checks++;
      if (outs !== exp_o) begin
        failures++;
        $display("FAIL reset cyc %0d: got %b expected %b", i, outs, exp_o);
      end
      @(posedge clk);
      #1;
    end
    // last row dropped vic_req from STALL: one idle cycle settles back to CPU
    {reset, vic_req, ext_req, cpu_we} = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vic_grant();
    logic [3:0] stim [0:6];
    logic [4:0] expv [0:6];
    stim = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    expv = '{5'b11100, 5'b01000, 5'b01000, 5'b01000, 5'b00010, 5'b00010, 5'b11100};
    for (int i = 0; i < 7; i++) begin
      {reset, vic_req, ext_req, cpu_we} = stim[i];
      sb.push_back(expv[i]);
      @(negedge clk);
      exp_o = sb.pop_front();
      checks++;
      if (outs !== exp_o) begin
        failures++;
        $display("FAIL vic_grant cyc %0d: got %b expected %b", i, outs, exp_o);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_brk_push();
    logic [3:0] stim [0:14];
    logic [4:0] expv [0:14];
    // three writes (grant on time), then four writes (grant slips one cycle)
    stim = '{4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
             4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    expv = '{5'b11100, 5'b11000, 5'b11000, 5'b01000, 5'b00010, 5'b00010, 5'b11100,
             5'b11100, 5'b11000, 5'b11000, 5'b11000, 5'b01000, 5'b00010, 5'b00010, 5'b11100};
    for (int i = 0; i < 15; i++) begin
      {reset, vic_req, ext_req, cpu_we} = stim[i];
      sb.push_back(expv[i]);
      @(negedge clk);
      exp_o = sb.pop_front();
      checks++;
      if (outs !== exp_o) begin
        failures++;
        $display("FAIL brk_push cyc %0d: got %b expected %b", i, outs, exp_o);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_abort();
    logic [3:0] stim [0:4];
    logic [4:0] expv [0:4];
    stim = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    expv = '{5'b11100, 5'b01000, 5'b01000, 5'b11100, 5'b11100};
    for (int i = 0; i < 5; i++) begin
      {reset, vic_req, ext_req, cpu_we} = stim[i];
      sb.push_back(expv[i]);
      @(negedge clk);
      exp_o = sb.pop_front();
      checks++;
      if (outs !== exp_o) begin
        failures++;
        $display("FAIL abort cyc %0d: got %b expected %b", i, outs, exp_o);
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef BUS_ARBITER_EXT_DMA_EN
  task automatic test_ext_dma();
    logic [3:0] stim [0:21];
    logic [4:0] expv [0:21];
    // both request: VIC first, then fresh EXT stall, then VIC preempts OWN_EXT;
    // then EXT stall stolen by VIC mid-lead without restarting the count
    stim = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0010, 4'b0010, 4'b0010,
             4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0100, 4'b0000, 4'b0000,
             4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0100, 4'b0000, 4'b0000};
    expv = '{5'b11100, 5'b01000, 5'b01000, 5'b01000, 5'b00010, 5'b00010, 5'b11100, 5'b01100,
             5'b01100, 5'b01100, 5'b00101, 5'b00101, 5'b00010, 5'b00010, 5'b11100,
             5'b11100, 5'b01100, 5'b01100, 5'b01000, 5'b00010, 5'b00010, 5'b11100};
    for (int i = 0; i < 22; i++) begin
      {reset, vic_req, ext_req, cpu_we} = stim[i];
      sb.push_back(expv[i]);
      @(negedge clk);
      exp_o = sb.pop_front();
      checks++;
      if (outs !== exp_o) begin
        failures++;
        $display("FAIL ext_dma cyc %0d: got %b expected %b", i, outs, exp_o);
      end
      @(posedge clk);
      #1;
    end
  endtask
`else
  task automatic test_ext_ignored();
    for (int i = 0; i < 5; i++) begin
      {reset, vic_req, ext_req, cpu_we} = 4'b0010;
      sb.push_back(5'b11100);
      @(negedge clk);
      exp_o = sb.pop_front();
      checks++;
      if (outs !== exp_o) begin
        failures++;
        $display("FAIL ext_ignored cyc %0d: got %b expected %b", i, outs, exp_o);
      end
      @(posedge clk);
      #1;
    end
    ext_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_vic_grant();
    test_brk_push();
    test_abort();
`ifdef BUS_ARBITER_EXT_DMA_EN
    test_ext_dma();
`else
    test_ext_ignored();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
